// File: rtl/reflet_spi_pkg.sv
// ============================================================
// reflet_spi_pkg -- register map, CTRL bit indices and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package reflet_spi_pkg;

   localparam int NUM_REGS = 4;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_CLKDIV = 2'd2;
   localparam logic [1:0] REG_CS     = 2'd3;

   localparam int CTRL_INT_EN = 0;
   localparam int CTRL_CPOL   = 1;
   localparam int CTRL_CPHA   = 2;
   localparam int CTRL_BUSY   = 3;
   localparam int CTRL_DONE   = 4;

   localparam int SPI_EDGES = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/reflet_spi_tick.sv
// ============================================================
// reflet_spi_tick -- sclk half-period divider, one tick per DIV+1 cycles
// Rev 1.0
// ============================================================
`default_nettype none

module reflet_spi_tick #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] div_i,
   output logic             tick_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;

   assign tick_o = en_i && (count_q == '0);

   // clear captures the divisor so later CLKDIV writes cannot disturb a running transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         reload_q <= '0;
      end else if (clear_i) begin
         count_q  <= div_i;
         reload_q <= div_i;
      end else if (en_i) begin
         if (count_q == '0) begin
            count_q <= reload_q;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/reflet_spi.sv
// ============================================================
// reflet_spi -- memory-mapped 8-bit SPI master with software chip select
// Rev 1.0
// ============================================================
`default_nettype none

module reflet_spi
   import reflet_spi_pkg::*;
#(
   parameter int                        WORDSIZE       = 16,
   parameter int                        BASE_ADDR_SIZE = 16,
   parameter logic [BASE_ADDR_SIZE-1:0] BASE_ADDR      = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic                      interrupt,
   input  logic [BASE_ADDR_SIZE-1:0] addr,
   input  logic [WORDSIZE-1:0]       data_in,
   output logic [WORDSIZE-1:0]       data_out,
   input  logic                      write_en,
   output logic                      sclk,
   output logic                      mosi,
   input  logic                      miso,
   output logic                      cs_n
);

   state_e              state_q;
   logic                int_en_q;
   logic                cpol_q;
   logic                cpha_q;
   logic                busy_q;
   logic                done_q;
   logic [WORDSIZE-1:0] clkdiv_q;
   logic                cs_q;
   logic [7:0]          rx_q;
   logic [7:0]          tx_q;
   logic [7:0]          rx_sh_q;
   logic [4:0]          edge_q;
   logic                cpol_sh_q;
   logic                cpha_sh_q;
   logic                sclk_q;
   logic                mosi_q;
   logic                interrupt_q;

   logic [BASE_ADDR_SIZE-1:0] w_offset;
   logic                      w_sel;
   logic [1:0]                w_reg;
   logic                      w_wr_ctrl;
   logic                      w_wr_data;
   logic                      w_wr_clkdiv;
   logic                      w_wr_cs;
   logic                      w_start;
   logic                      w_tick;
   logic [4:0]                w_edge_n;
   logic                      w_sample;
   logic                      w_shift;
   logic [2:0]                w_bit;

   assign w_offset    = addr - BASE_ADDR;
   assign w_sel       = enable && (w_offset < BASE_ADDR_SIZE'(NUM_REGS));
   assign w_reg       = w_offset[1:0];
   assign w_wr_ctrl   = w_sel && write_en && (w_reg == REG_CTRL);
   assign w_wr_data   = w_sel && write_en && (w_reg == REG_DATA);
   assign w_wr_clkdiv = w_sel && write_en && (w_reg == REG_CLKDIV);
   assign w_wr_cs     = w_sel && write_en && (w_reg == REG_CS);
   assign w_start     = w_wr_data && (state_q == ST_IDLE);

   // Edge n (1..16): cpha=0 samples odd edges and shifts on even edges 2..14,
   // cpha=1 shifts on odd edges and samples even ones. Either way the bit
   // presented after a shift edge is bit 7 - n/2.
   assign w_edge_n = edge_q + 5'd1;
   assign w_sample = cpha_sh_q ? ~w_edge_n[0] : w_edge_n[0];
   assign w_shift  = cpha_sh_q ? w_edge_n[0]
                               : (~w_edge_n[0] && (w_edge_n != 5'(SPI_EDGES)));
   assign w_bit    = 3'd7 - w_edge_n[3:1];

   reflet_spi_tick #(
      .WIDTH (WORDSIZE)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .clear_i (w_start),
      .en_i    (state_q == ST_SHIFT),
      .div_i   (clkdiv_q),
      .tick_o  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         int_en_q    <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clkdiv_q    <= '0;
         cs_q        <= 1'b1;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         rx_sh_q     <= 8'h00;
         edge_q      <= 5'd0;
         cpol_sh_q   <= 1'b0;
         cpha_sh_q   <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         interrupt_q <= 1'b0;
      end else begin
         interrupt_q <= 1'b0;

         if (w_wr_ctrl) begin
            int_en_q <= data_in[CTRL_INT_EN];
            cpol_q   <= data_in[CTRL_CPOL];
            cpha_q   <= data_in[CTRL_CPHA];
            if (data_in[CTRL_DONE]) begin
               done_q <= 1'b0;
            end
         end
         if (w_wr_clkdiv) begin
            clkdiv_q <= data_in;
         end
         if (w_wr_cs) begin
            cs_q <= data_in[0];
         end

         case (state_q)
            ST_IDLE: begin
               sclk_q <= cpol_q;
               if (w_start) begin
                  tx_q      <= data_in[7:0];
                  rx_sh_q   <= 8'h00;
                  edge_q    <= 5'd0;
                  mosi_q    <= data_in[7];
                  cpol_sh_q <= cpol_q;
                  cpha_sh_q <= cpha_q;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  state_q   <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (w_tick) begin
                  sclk_q <= ~sclk_q;
                  edge_q <= w_edge_n;
                  if (w_sample) begin
                     rx_sh_q <= {rx_sh_q[6:0], miso};
                  end
                  if (w_shift) begin
                     mosi_q <= tx_q[w_bit];
                  end
                  if (w_edge_n == 5'(SPI_EDGES)) begin
                     state_q <= ST_DONE;
                  end
               end
            end

            // Placed after the CTRL write so a same-cycle done-clear loses.
            ST_DONE: begin
               rx_q        <= rx_sh_q;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               interrupt_q <= int_en_q;
               sclk_q      <= cpol_q;
               state_q     <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      data_out = '0;
      if (w_sel) begin
         case (w_reg)
            REG_CTRL: begin
               data_out[CTRL_INT_EN] = int_en_q;
               data_out[CTRL_CPOL]   = cpol_q;
               data_out[CTRL_CPHA]   = cpha_q;
               data_out[CTRL_BUSY]   = busy_q;
               data_out[CTRL_DONE]   = done_q;
            end
            REG_DATA:   data_out[7:0] = rx_q;
            REG_CLKDIV: data_out      = clkdiv_q;
            REG_CS:     data_out[0]   = cs_q;
            default:    data_out      = '0;
         endcase
      end
   end

   assign interrupt = interrupt_q;
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign cs_n      = cs_q;

   logic w_unused;
   assign w_unused = cpol_sh_q;

endmodule

`default_nettype wire

// File: tb/tb_reflet_spi.sv
// ============================================================
// tb_reflet_spi -- randomized self-checking bench acting as SPI slave
// Rev 1.0
// ============================================================
`default_nettype none

module tb_reflet_spi;

   localparam logic [15:0] BASE = 16'h0040;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        write_en = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        interrupt, sclk, mosi, miso, cs_n;

   int n_cmp = 0;
   int n_mis = 0;

   // Slave model: counts sclk edges per transfer, records mosi on sample
   // edges and serves slave_byte MSB first, changing after each sample edge.
   int         arm_seq = 0, arm_seen = 0;
   int         edges = 0, samp = 0, gap = 0, gap_min = 0, gap_max = 0, irq_cnt = 0;
   int         cyc = 0;
   logic [7:0] cap = '0, slave_byte = '0;
   logic       m_loop = 1'b0, m_cpha = 1'b0, prev_sclk = 1'b0;

   assign miso = m_loop ? mosi : ((samp < 8) ? slave_byte[3'(7 - samp)] : 1'b0);

   reflet_spi #(
      .WORDSIZE       (16),
      .BASE_ADDR_SIZE (16),
      .BASE_ADDR      (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .interrupt (interrupt),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .write_en  (write_en),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .cs_n      (cs_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (arm_seq != arm_seen) begin
         arm_seen = arm_seq;
         edges = 0; samp = 0; cap = '0; gap = 0;
         gap_min = 1000; gap_max = 0; irq_cnt = 0;
      end else begin
         if (interrupt) irq_cnt++;
         if (sclk != prev_sclk) begin
            if (edges > 0) begin
               if (gap + 1 < gap_min) gap_min = gap + 1;
               if (gap + 1 > gap_max) gap_max = gap + 1;
            end
            edges++;
            if (((edges % 2) == 0) == m_cpha) begin
               cap = {cap[6:0], mosi};
               samp++;
            end
            gap = 0;
         end else begin
            gap++;
         end
      end
      prev_sclk = sclk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic en = 1'b1);
      @(negedge clk);
      enable = en; write_en = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      enable = 1'b0; write_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
      enable = 1'b1; addr = a;
      #1;
      d = data_out;
      enable = 1'b0;
   endtask

   int t0 = 0;

   task automatic start_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                             input logic [15:0] div, input logic ie, input logic loop,
                             input logic [7:0] sbyte);
      bus_wr(BASE + 16'd0, {13'd0, cpha, cpol, ie});
      bus_wr(BASE + 16'd2, div);
      m_cpha = cpha; m_loop = loop; slave_byte = sbyte;
      arm_seq++;
      @(negedge clk);
      @(negedge clk);
      chk("sclk_idle", sclk, cpol);
      bus_wr(BASE + 16'd1, {8'd0, tx});
      t0 = cyc;
   endtask

   task automatic finish_xfer(input logic [7:0] tx, input logic [7:0] exp_rx, input logic cpol,
                              input logic cpha, input logic [15:0] div, input logic ie);
      logic [15:0] r;
      int          n;
      int          busy_cyc;
      n = 0;
      bus_rd(BASE, r);
      while (r[3] && n < 5000) begin
         @(negedge clk);
         n++;
         bus_rd(BASE, r);
      end
      busy_cyc = cyc - t0;
      chk("busy_cycles", busy_cyc, 16 * (div + 1) + 1);
      repeat (3) @(negedge clk);
      chk("sclk_edges", edges, 16);
      chk("mosi_bits", cap, tx);
      chk("half_period_min", gap_min, div + 1);
      chk("half_period_max", gap_max, div + 1);
      chk("sclk_rest", sclk, cpol);
      chk("irq_pulses", irq_cnt, ie);
      bus_rd(BASE + 16'd1, r);
      chk("rx_byte", r, {8'd0, exp_rx});
      bus_rd(BASE, r);
      chk("ctrl_done", r, {11'd0, 1'b1, 1'b0, cpha, cpol, ie});
   endtask

   initial begin
      logic [15:0] r;
      logic [7:0]  tx, sb;
      logic [15:0] dv;
      logic        pol, pha, ie, lp, cs;
      int          n;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus_rd(BASE + 16'd0, r); chk("rst_ctrl", r, 16'h0000);
      bus_rd(BASE + 16'd1, r); chk("rst_data", r, 16'h0000);
      bus_rd(BASE + 16'd2, r); chk("rst_clkdiv", r, 16'h0000);
      bus_rd(BASE + 16'd3, r); chk("rst_cs", r, 16'h0001);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_irq", interrupt, 1'b0);

      // Out-of-range and disabled accesses
      bus_wr(BASE + 16'd4, 16'h00FF);
      bus_wr(BASE - 16'd1, 16'h00FF);
      bus_wr(BASE + 16'd2, 16'h0077, 1'b0);
      bus_wr(BASE + 16'd3, 16'h0000, 1'b0);
      bus_rd(BASE + 16'd4, r); chk("oor_rd_hi", r, 16'h0000);
      bus_rd(BASE - 16'd1, r); chk("oor_rd_lo", r, 16'h0000);
      addr = BASE + 16'd3; enable = 1'b0; #1;
      chk("dis_rd", data_out, 16'h0000);
      bus_rd(BASE + 16'd2, r); chk("oor_wr_clkdiv", r, 16'h0000);
      bus_rd(BASE + 16'd0, r); chk("oor_wr_ctrl", r, 16'h0000);
      chk("oor_wr_cs", cs_n, 1'b1);

      // Mode 0, CLKDIV=3, loopback
      start_xfer(8'hA5, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 8'h00);
      finish_xfer(8'hA5, 8'hA5, 1'b0, 1'b0, 16'd3, 1'b0);

      // Mode 3 with interrupt, miso held high, then done clear
      start_xfer(8'h3C, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 8'hFF);
      finish_xfer(8'h3C, 8'hFF, 1'b1, 1'b1, 16'd1, 1'b1);
      bus_wr(BASE, 16'h0017);
      bus_rd(BASE, r); chk("done_clear", r, 16'h0007);

      // DATA write while busy is ignored
      start_xfer(8'h80, 1'b0, 1'b0, 16'd1, 1'b0, 1'b1, 8'h00);
      repeat (10) @(negedge clk);
      bus_wr(BASE + 16'd1, 16'h0011);
      finish_xfer(8'h80, 8'h80, 1'b0, 1'b0, 16'd1, 1'b0);
      repeat (50) @(negedge clk);
      chk("no_restart_edges", edges, 16);
      bus_rd(BASE, r); chk("no_restart_busy", r[3], 1'b0);

      // Reset in the middle of a transfer
      bus_wr(BASE + 16'd3, 16'h0000);
      chk("cs_low", cs_n, 1'b0);
      start_xfer(8'h5A, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'hC3);
      n = 0;
      while (edges < 7 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("edge7_reached", edges, 7);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus_rd(BASE, r); chk("abort_ctrl", r, 16'h0000);
      chk("abort_sclk", sclk, 1'b0);
      chk("abort_cs_n", cs_n, 1'b1);
      repeat (40) @(negedge clk);
      chk("abort_no_irq", irq_cnt, 0);
      bus_rd(BASE + 16'd1, r); chk("abort_rx", r, 16'h0000);

      // Randomized transfers
      for (int i = 0; i < 10; i++) begin
         tx  = 8'($urandom);
         sb  = 8'($urandom);
         pol = 1'($urandom);
         pha = 1'($urandom);
         ie  = 1'($urandom);
         lp  = 1'($urandom);
         cs  = 1'($urandom);
         dv  = 16'($urandom_range(0, 3));
         bus_wr(BASE + 16'd3, {15'd0, cs});
         start_xfer(tx, pol, pha, dv, ie, lp, sb);
         finish_xfer(tx, lp ? tx : sb, pol, pha, dv, ie);
         chk("cs_hold", cs_n, cs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/reflet_spi.md
Name: reflet_spi

Overview:
Memory-mapped SPI master peripheral attached to the reflet peripheral bus, alongside gpio/timer/uart/pwm. It consumes the bus decode signals (enable, offset address, data, write_en) and runs 8-bit full-duplex transfers on sclk/mosi/miso with a software-driven chip select. It raises a one-cycle interrupt to the exti block on transfer completion.

Parameters:
wordsize, 16, CPU data width; registers are zero-extended to it on read.
base_addr_size, 16, width of addr input.
base_addr, 0, address of register 0; the block occupies base_addr..base_addr+3.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  bus access qualifier; the block ignores the bus when low
interrupt  out  1  one-cycle transfer-complete pulse
addr  in  base_addr_size  bus address
data_in  in  wordsize  write data
data_out  out  wordsize  read data; all zero unless enable is high and addr is in range (OR-combined bus)
write_en  in  1  write strobe, sampled at the rising edge of clk
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  1  chip select, active low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Register map:
  - 0 CTRL: bit0 int_en (RW), bit1 cpol (RW), bit2 cpha (RW), bit3 busy (RO), bit4 done (RO; a write with bit4=1 clears it).
  - 1 DATA: a write starts a transfer with data_in[7:0]; a read returns the last received byte.
  - 2 CLKDIV: [wordsize-1:0] RW; half-period of sclk = CLKDIV+1 clk cycles.
  - 3 CS: bit0 drives cs_n directly (RW).
- Reset values: int_en=cpol=cpha=0, busy=done=0, CLKDIV=0, rx byte=0, cs_n=1, sclk=cpol (0), mosi=0, interrupt=0. Any in-flight transfer is aborted immediately on reset.
- Reads are combinational from registers. Writes take effect at the clock edge where enable & write_en & addr-in-range.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: a DATA write loads the shift register, clears done, zeroes the edge counter and divider, and goes to SHIFT next cycle (busy=1 from T+1).
  - cpha=0: mosi presents bit7 at T+1.
  - SHIFT: every CLKDIV+1 cycles a tick toggles sclk; 16 ticks per transfer, MSB first.
    - cpha=0: sample miso on odd edges (1,3,..15); shift out on even edges (2..14).
    - cpha=1: shift out on odd edges; sample on even edges.
  - After the 16th tick, go to DONE. sclk has returned to cpol.
  - DONE (one cycle): rx byte latched, busy=0, done=1, interrupt=int_en. Then return to IDLE.
  - busy is therefore high for exactly 16*(CLKDIV+1)+1 cycles.
- DATA write while busy: ignored (no restart, tx byte unchanged).
- CTRL/CLKDIV writes while busy: stored, but cpol/cpha/CLKDIV take effect only at the next transfer start (shadowed at start).
- Done-clear write in the same cycle as DONE: set wins.
- cs_n is never touched by the FSM.
- In IDLE, sclk follows the current cpol.
- CLKDIV=0: sclk toggles every cycle (clk/2).
- Divider counter wraps to 0 on every tick.

Decomposition:
- Shared package: register offsets (CTRL=0, DATA=1, CLKDIV=2, CS=3), CTRL bit indices, FSM state encoding, register count 4 (for the top-level memory map).
- One sub-module, reflet_spi_tick: loadable down-counter with clear; emits a one-cycle tick every CLKDIV+1 cycles while enabled.

Test Plan:
- Reset -> read CTRL=0x0000, CLKDIV=0, CS=1; cs_n=1, sclk=0, interrupt=0.
- Mode 0, CLKDIV=3, miso looped to mosi, write DATA=0xA5 -> 16 sclk edges, each half-period 4 clk; mosi sequence 1,0,1,0,0,1,0,1; busy for 65 cycles; DATA read=0xA5; done=1.
- int_en=1, cpol=1, cpha=1, miso tied 1, write 0x3C -> sclk idles high; exactly one interrupt pulse; DATA read=0xFF; CTRL bit4 write 1 -> done=0.
- Write DATA=0x11 mid-transfer of 0x80 -> transfer still shifts 0x80; no second transfer starts.
- Assert reset at edge 7 of a transfer -> next cycle busy=0, sclk=0, cs_n=1, no interrupt; a fresh transfer afterwards completes normally.
- Read an address outside base_addr..+3, or with enable=0 -> data_out=0; writes to those addresses change nothing.
